timer_counter: RTL and testbench

//   Memory-mapped countdown timer: a responder on the processor bus (PrAddr/PrWD/PrWE/PrRD) behind the system bridge.

---
 rtl/timer_counter.sv | 128 ++++++++++++
 tb/tb_timer_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot and periodic modes driving HWInt.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_counter #(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        wr_ctrl, wr_preset;
  logic        en, periodic, tick;

  assign wr_ctrl   = sel & we & (addr == 2'd0);
  assign wr_preset = sel & we & (addr == 2'd1);
  assign en        = ctrl_q[0];
  assign periodic  = (ctrl_q[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE_DIV - 1);

  logic [15:0] pre_q, pre_d;

  assign tick = (pre_q == PRE_MAX);

  // Runs only while counting; any exit from CNT clears it.
  always_comb begin
    pre_d = '0;
    if (state_q == S_CNT && en && !tick)
      pre_d = pre_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = '0;
            irq_flag_d = 1'b1;
            state_d    = S_INT;
          end
        end
      end
      S_INT: begin
        state_d = S_IDLE;
        if (periodic) irq_flag_d = 1'b0;
        else          ctrl_d[0]  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Bus writes override anything the FSM did this cycle.
    if (wr_ctrl) begin
      ctrl_d     = wdata[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) preset_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      2'd0:    rdata = {28'd0, ctrl_q};
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = '0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: expected values are queued at stimulus
// time and compared when the DUT output is sampled.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

`ifdef TIMER_PRESCALE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  always #5 clk = ~clk;

  timer_counter #(.PRESCALE_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    sel   = 1'b0;
    we    = 1'b0;
  endtask

  task automatic expect_rd(input string tag, input logic [1:0] a,
                           input logic [31:0] v);
    addr = a;
    sb_push(tag, v);
    #1;
    sb_pop(rdata);
  endtask

  task automatic expect_irq(input string tag, input logic v);
    sb_push(tag, {31'd0, v});
    #1;
    sb_pop({31'd0, irq});
  endtask

  initial begin
    reset = 1'b1;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    tick();
    tick();
    reset = 1'b0;

    expect_rd("rst_ctrl", 2'd0, 32'd0);
    expect_rd("rst_preset", 2'd1, 32'd0);
    expect_rd("rst_count", 2'd2, 32'd0);
    expect_rd("rst_rsvd", 2'd3, 32'd0);
    expect_irq("rst_irq", 1'b0);

    wr(2'd0, 32'hFFFF_FFF0);
    expect_rd("ctrl_hi_bits", 2'd0, 32'd0);
    wr(2'd3, 32'hDEAD_BEEF);
    expect_rd("rsvd_wr", 2'd3, 32'd0);
    sel = 1'b0; we = 1'b1; addr = 2'd1; wdata = 32'h55;
    tick();
    we = 1'b0;
    expect_rd("nosel_wr", 2'd1, 32'd0);

`ifndef TIMER_PRESCALE_EN
    // one-shot, PRESET=5
    wr(2'd1, 32'd5);
    expect_rd("preset5", 2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      sb_push($sformatf("os_count_%0d", k),
              (k < 2) ? 32'd0 : ((k - 2 >= 5) ? 32'd0 : 32'(5 - (k - 2))));
      sb_push($sformatf("os_irq_%0d", k), {31'd0, k >= 7});
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      addr = 2'd2;
      #1;
      sb_pop(rdata);
      sb_pop({31'd0, irq});
    end
    expect_rd("os_ctrl_after", 2'd0, 32'h8);
    tick();
    tick();
    expect_irq("os_irq_held", 1'b1);
    expect_rd("os_count_held", 2'd2, 32'd0);
    wr(2'd0, 32'h0);
    expect_irq("os_irq_clr", 1'b0);

    // PRESET=0 acts like PRESET=1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    tick();
    expect_irq("p0_irq_t2", 1'b0);
    tick();
    expect_irq("p0_irq_t3", 1'b1);
    wr(2'd0, 32'h0);

    // periodic, PRESET=3 -> period 6
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int c = 1; c <= 24; c++)
      sb_push($sformatf("per_irq_%0d", c),
              {31'd0, (c >= 5) && ((c - 5) % 6 == 0)});
    for (int c = 1; c <= 24; c++) begin
      tick();
      #1;
      sb_pop({31'd0, irq});
    end
    wr(2'd0, 32'h0);
    tick();
    tick();
    expect_irq("per_stopped", 1'b0);

    // masked: flag set but irq stays low, CTRL write clears flag
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int c = 1; c <= 14; c++) begin
      tick();
      expect_irq($sformatf("mask_irq_%0d", c), 1'b0);
    end
    expect_rd("mask_count", 2'd2, 32'd0);
    expect_rd("mask_ctrl", 2'd0, 32'd0);
    wr(2'd0, 32'h8);
    expect_irq("unmask_irq", 1'b0);
    tick();
    tick();
    expect_irq("unmask_irq2", 1'b0);
    wr(2'd0, 32'h0);

    // mid-count writes
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h1);
    tick();
    tick();
    expect_rd("mid_count8", 2'd2, 32'd8);
    wr(2'd2, 32'h1234);
    expect_rd("mid_count_ro", 2'd2, 32'd7);
    wr(2'd1, 32'd2);
    expect_rd("mid_count_pre", 2'd2, 32'd6);
    expect_rd("mid_preset2", 2'd1, 32'd2);
    tick();
    wr(2'd0, 32'h0);
    expect_rd("mid_ctrl0", 2'd0, 32'd0);
    for (int c = 0; c < 4; c++) tick();
    expect_rd("mid_freeze", 2'd2, 32'd4);
    expect_irq("mid_irq", 1'b0);

    // reset mid-count in periodic mode
    wr(2'd1, 32'd9);
    wr(2'd0, 32'hB);
    for (int c = 0; c < 4; c++) tick();
    expect_rd("rr_count7", 2'd2, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_rd("rr_ctrl", 2'd0, 32'd0);
    expect_rd("rr_preset", 2'd1, 32'd0);
    expect_rd("rr_count", 2'd2, 32'd0);
    expect_irq("rr_irq", 1'b0);
    tick();
    tick();
    tick();
    expect_rd("rr_idle", 2'd2, 32'd0);
`endif

    // PRESET=2: irq at 2*DIV+2 cycles after enable
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int c = 1; c <= 2 * DIV + 3; c++) begin
      tick();
      expect_irq($sformatf("lat_irq_%0d", c), c >= 2 * DIV + 2);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
